// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch states, instruction field positions and
// redirect-select encoding used by the fetch stage and later pipeline stages.
package cpu_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    HAVE  = 1'b1
  } fetch_state_e;

  localparam int INSTR_BYTES = 4;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_MSB = 25;
  localparam int TARGET_LSB = 0;

  typedef enum logic [1:0] {
    SEL_NONE   = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_JR     = 2'd3
  } redirect_sel_e;

  // Priority encode the redirect selects: jr beats jump beats branch.
  function automatic redirect_sel_e redirect_select(input logic br_taken,
                                                    input logic jump,
                                                    input logic jr);
    redirect_sel_e sel;
    if (jr) begin
      sel = SEL_JR;
    end else if (jump) begin
      sel = SEL_JUMP;
    end else if (br_taken) begin
      sel = SEL_BRANCH;
    end else begin
      sel = SEL_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational redirect-target calculation: link value, branch and jump
// adders and the priority mux choosing which target (if any) applies.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]          i_instr_pc,
  input  logic [IMM_MSB:IMM_LSB]    i_imm,
  input  logic [TARGET_MSB:TARGET_LSB] i_target,
  input  logic                      i_br_taken,
  input  logic                      i_jump,
  input  logic                      i_jr,
  input  logic [WIDTH-1:0]          i_jr_target,
  output logic [WIDTH-1:0]          o_pc_plus4,
  output logic                      o_redirect,
  output logic [WIDTH-1:0]          o_target
);

  logic [WIDTH-1:0] w_pc_plus4;
  logic [WIDTH-1:0] w_imm_ext;
  logic [WIDTH-1:0] w_branch_target;
  logic [WIDTH-1:0] w_jump_target;
  redirect_sel_e    w_sel;

  assign w_pc_plus4      = i_instr_pc + WIDTH'(INSTR_BYTES);
  assign w_imm_ext       = {{(WIDTH-16){i_imm[IMM_MSB]}}, i_imm};
  assign w_branch_target = w_pc_plus4 + (w_imm_ext << 2);
  assign w_jump_target   = {w_pc_plus4[WIDTH-1:TARGET_MSB+3], i_target, 2'b00};
  assign w_sel           = redirect_select(i_br_taken, i_jump, i_jr);
  assign o_pc_plus4      = w_pc_plus4;

  // Pick the winning target; with no select high there is no redirect.
  always_comb begin
    o_redirect = 1'b1;
    o_target   = w_pc_plus4;
    case (w_sel)
      SEL_JR:     o_target = i_jr_target;
      SEL_JUMP:   o_target = w_jump_target;
      SEL_BRANCH: o_target = w_branch_target;
      default:    o_redirect = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the req/ready handshake with
// instruction memory and holds one fetched instruction for decode.
// WIDTH must be at least 32 so the instruction fields fit.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic [WIDTH-1:0] pc_plus4,
  input  logic             stall,
  input  logic             br_taken,
  input  logic             jump,
  input  logic             jr,
  input  logic [WIDTH-1:0] jr_target
);

  fetch_state_e     r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] r_instr_pc;
  logic             r_instr_valid;
  logic             r_redirect_pending;
  logic [WIDTH-1:0] r_redirect_target;

  fetch_state_e     w_state_next;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_instr_next;
  logic [WIDTH-1:0] w_instr_pc_next;
  logic             w_instr_valid_next;
  logic             w_redirect_pending_next;
  logic [WIDTH-1:0] w_redirect_target_next;

  logic             w_redirect;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_pc_plus4;

  next_pc_calc #(
    .WIDTH(WIDTH)
  ) u_next_pc_calc (
    .i_instr_pc (r_instr_pc),
    .i_imm      (r_instr[IMM_MSB:IMM_LSB]),
    .i_target   (r_instr[TARGET_MSB:TARGET_LSB]),
    .i_br_taken (br_taken),
    .i_jump     (jump),
    .i_jr       (jr),
    .i_jr_target(jr_target),
    .o_pc_plus4 (w_pc_plus4),
    .o_redirect (w_redirect),
    .o_target   (w_target)
  );

  // The request is gated by reset_n so it drops the instant reset asserts,
  // abandoning any request in flight.
  assign imem_req    = reset_n && (r_state == FETCH);
  assign imem_addr   = r_pc;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign pc_plus4    = w_pc_plus4;

  // State and datapath registers; everything returns to the reset vector.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state            <= FETCH;
      r_pc               <= RESET_VECTOR;
      r_instr            <= '0;
      r_instr_pc         <= '0;
      r_instr_valid      <= 1'b0;
      r_redirect_pending <= 1'b0;
      r_redirect_target  <= '0;
    end else begin
      r_state            <= w_state_next;
      r_pc               <= w_pc_next;
      r_instr            <= w_instr_next;
      r_instr_pc         <= w_instr_pc_next;
      r_instr_valid      <= w_instr_valid_next;
      r_redirect_pending <= w_redirect_pending_next;
      r_redirect_target  <= w_redirect_target_next;
    end
  end

  // Next-state logic: PC stays put while a request waits, so a redirect seen
  // mid-wait is parked and applied (with the data dropped) once memory answers.
  always_comb begin
    w_state_next            = r_state;
    w_pc_next               = r_pc;
    w_instr_next            = r_instr;
    w_instr_pc_next         = r_instr_pc;
    w_instr_valid_next      = r_instr_valid;
    w_redirect_pending_next = r_redirect_pending;
    w_redirect_target_next  = r_redirect_target;
    case (r_state)
      FETCH: begin
        if (imem_ready) begin
          w_redirect_pending_next = 1'b0;
          if (w_redirect) begin
            w_pc_next = w_target;
          end else if (r_redirect_pending) begin
            w_pc_next = r_redirect_target;
          end else begin
            w_instr_next       = imem_rdata;
            w_instr_pc_next    = r_pc;
            w_pc_next          = r_pc + WIDTH'(INSTR_BYTES);
            w_instr_valid_next = 1'b1;
            w_state_next       = HAVE;
          end
        end else if (w_redirect) begin
          w_redirect_pending_next = 1'b1;
          w_redirect_target_next  = w_target;
        end
      end
      HAVE: begin
        if (!stall) begin
          w_instr_valid_next = 1'b0;
          w_state_next       = FETCH;
          if (w_redirect) begin
            w_pc_next = w_target;
          end
        end
      end
      default: begin
        w_state_next = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed stimulus, a transaction-level model of
// the fetch stage compared every cycle, plus hand-computed literal checks.
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        stall;
  logic        br_taken;
  logic        jump;
  logic        jr;
  logic [31:0] jr_target;

  int vectorCount = 0;
  int failCount   = 0;

  logic [31:0] memArr [logic [31:0]];

  logic [31:0] mPc;
  logic [31:0] mInstr;
  logic [31:0] mInstrPc;
  logic        mHolding;
  logic        mPendValid;
  logic [31:0] mPendTgt;

  fetch_unit #(
    .WIDTH(32),
    .RESET_VECTOR(32'h0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .pc_plus4   (pc_plus4),
    .stall      (stall),
    .br_taken   (br_taken),
    .jump       (jump),
    .jr         (jr),
    .jr_target  (jr_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents; unlisted addresses return a tagged pattern.
  function automatic logic [31:0] memRead(input logic [31:0] addr);
    if (memArr.exists(addr)) begin
      return memArr[addr];
    end
    return addr ^ 32'hC0DE_0000;
  endfunction

  // Redirect target straight from the ISA rules, using signed integer maths.
  function automatic logic [31:0] modelTarget(input logic [31:0] ipc,
                                              input logic [31:0] ins,
                                              input logic        selJr,
                                              input logic        selJump,
                                              input logic [31:0] jt);
    int          off;
    logic [15:0] imm;
    logic [25:0] field;
    if (selJr) begin
      return jt;
    end
    if (selJump) begin
      field = ins[25:0];
      return ((ipc + 32'd4) & 32'hF000_0000) | ({6'b0, field} * 32'd4);
    end
    imm = ins[15:0];
    off = int'(signed'(imm)) * 4;
    return ipc + 32'd4 + 32'(off);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic stl, input logic br,
                               input logic jmp, input logic j, input logic [31:0] jt);
    imem_ready = rdy;
    stall      = stl;
    br_taken   = br;
    jump       = jmp;
    jr         = j;
    jr_target  = jt;
    imem_rdata = memRead(imem_addr);
    @(posedge clk);
    #1;
  endtask

  // Reference model: one instruction slot, a PC and a parked redirect.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mPc        <= 32'h0;
      mInstr     <= 32'h0;
      mInstrPc   <= 32'h0;
      mHolding   <= 1'b0;
      mPendValid <= 1'b0;
      mPendTgt   <= 32'h0;
    end else if (!mHolding) begin
      if (imem_ready) begin
        mPendValid <= 1'b0;
        if (jr || jump || br_taken) begin
          mPc <= modelTarget(mInstrPc, mInstr, jr, jump, jr_target);
        end else if (mPendValid) begin
          mPc <= mPendTgt;
        end else begin
          mInstr   <= memRead(mPc);
          mInstrPc <= mPc;
          mPc      <= mPc + 32'd4;
          mHolding <= 1'b1;
        end
      end else if (jr || jump || br_taken) begin
        mPendValid <= 1'b1;
        mPendTgt   <= modelTarget(mInstrPc, mInstr, jr, jump, jr_target);
      end
    end else if (!stall) begin
      mHolding <= 1'b0;
      if (jr || jump || br_taken) begin
        mPc <= modelTarget(mInstrPc, mInstr, jr, jump, jr_target);
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    checkOutput("model imem_req", {31'b0, imem_req}, {31'b0, reset_n && !mHolding});
    checkOutput("model imem_addr", imem_addr, mPc);
    checkOutput("model instr_valid", {31'b0, instr_valid}, {31'b0, mHolding});
    checkOutput("model instr", instr, mInstr);
    checkOutput("model instr_pc", instr_pc, mInstrPc);
    checkOutput("model pc_plus4", pc_plus4, mInstrPc + 32'd4);
  end

  initial begin
    memArr[32'h0000_0000] = 32'h2008_0005;
    memArr[32'h0000_0004] = 32'h2009_000A;
    memArr[32'h0000_0008] = 32'h200A_0001;
    memArr[32'h0000_000C] = 32'h0000_0000;
    memArr[32'h0000_0010] = 32'h1000_FFFC;
    memArr[32'h0040_0000] = 32'h0800_0040;

    reset_n    = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    stall      = 1'b0;
    br_taken   = 1'b0;
    jump       = 1'b0;
    jr         = 1'b0;
    jr_target  = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset imem_req", {31'b0, imem_req}, 32'h0);
    checkOutput("reset instr_valid", {31'b0, instr_valid}, 32'h0);
    checkOutput("reset imem_addr", imem_addr, 32'h0);
    checkOutput("reset instr", instr, 32'h0);
    reset_n = 1'b1;
    #1;
    checkOutput("first req", {31'b0, imem_req}, 32'h1);
    checkOutput("first addr", imem_addr, 32'h0);

    // Zero-wait fetches from 0 and 4.
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("i0 valid", {31'b0, instr_valid}, 32'h1);
    checkOutput("i0 instr", instr, 32'h2008_0005);
    checkOutput("i0 instr_pc", instr_pc, 32'h0);
    checkOutput("i0 pc_plus4", pc_plus4, 32'h4);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("i1 fetch valid", {31'b0, instr_valid}, 32'h0);
    checkOutput("i1 fetch addr", imem_addr, 32'h4);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("i1 instr", instr, 32'h2009_000A);
    checkOutput("i1 instr_pc", instr_pc, 32'h4);
    checkOutput("i1 pc_plus4", pc_plus4, 32'h8);

    // Three wait cycles at 0x8: request and address must hold.
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("wait req", {31'b0, imem_req}, 32'h1);
      checkOutput("wait addr", imem_addr, 32'h8);
      applyStimulus(0, 0, 0, 0, 0, 0);
    end
    checkOutput("ready req", {31'b0, imem_req}, 32'h1);
    checkOutput("ready addr", imem_addr, 32'h8);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("after wait valid", {31'b0, instr_valid}, 32'h1);
    checkOutput("after wait instr_pc", instr_pc, 32'h8);

    // Stall holds the instruction.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0);
      checkOutput("stall valid", {31'b0, instr_valid}, 32'h1);
      checkOutput("stall req", {31'b0, imem_req}, 32'h0);
      checkOutput("stall instr_pc", instr_pc, 32'h8);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("after stall addr", imem_addr, 32'hC);

    // Backward branch at 0x10.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("branch instr", instr, 32'h1000_FFFC);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("branch target", imem_addr, 32'h4);

    // jr beats br_taken.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 1, 32'h1000);
    checkOutput("jr priority", imem_addr, 32'h1000);

    // J at 0x00400000; jump also beats br_taken.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h0040_0000);
    checkOutput("jr to 0x400000", imem_addr, 32'h0040_0000);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("jump instr", instr, 32'h0800_0040);
    checkOutput("jal link", pc_plus4, 32'h0040_0004);
    applyStimulus(0, 0, 1, 1, 0, 0);
    checkOutput("jump target", imem_addr, 32'h100);

    // Redirects during a waiting fetch at 0x14; second one wins.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h14);
    checkOutput("jr to 0x14", imem_addr, 32'h14);
    applyStimulus(0, 0, 0, 0, 1, 32'h300);
    checkOutput("pending addr hold 1", imem_addr, 32'h14);
    checkOutput("pending req hold 1", {31'b0, imem_req}, 32'h1);
    applyStimulus(0, 0, 0, 0, 1, 32'h200);
    checkOutput("pending addr hold 2", imem_addr, 32'h14);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("discard valid", {31'b0, instr_valid}, 32'h0);
    checkOutput("discard next addr", imem_addr, 32'h200);
    checkOutput("discard req", {31'b0, imem_req}, 32'h1);

    // Redirect arriving in the same cycle as ready.
    applyStimulus(1, 0, 0, 0, 1, 32'h40);
    checkOutput("same-cycle redirect valid", {31'b0, instr_valid}, 32'h0);
    checkOutput("same-cycle redirect addr", imem_addr, 32'h40);

    // Reset pulse in the middle of a waiting fetch.
    imem_ready = 1'b0;
    jr         = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("mid reset req", {31'b0, imem_req}, 32'h0);
    checkOutput("mid reset addr", imem_addr, 32'h0);
    checkOutput("mid reset valid", {31'b0, instr_valid}, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Redirect selects ignored while stalled in HAVE.
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("post reset instr", instr, 32'h2008_0005);
    applyStimulus(0, 1, 1, 0, 0, 0);
    checkOutput("stalled branch valid", {31'b0, instr_valid}, 32'h1);
    checkOutput("stalled branch instr_pc", instr_pc, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("stalled branch ignored", imem_addr, 32'h4);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
    $finish;
  end

endmodule
